// File: rtl/thumb_fetch_queue_if.sv
// thumb_fetch_queue_if
//   Bundles the memory fetch port and the executor command port of the
//   Thumb fetch queue.
//   master : the fetch queue (drives mem_req/mem_addr and cmd_*)
//   slave  : the surrounding system (memory + executor + redirect source)
//   Signals:
//     mem_req     fetch request (registered)
//     mem_addr    word address, bits[1:0] = 0
//     mem_ack     read data valid, completes the request
//     mem_rdata   fetched 32-bit word
//     cmd_valid   cmd/cmd_pc hold a valid halfword
//     cmd         Thumb halfword to the executor
//     cmd_pc      address of cmd
//     cmd_ready   executor accepts cmd this cycle
//     redirect    flush and restart fetch
//     redirect_pc new PC (bit 0 ignored)
interface thumb_fetch_queue_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        cmd_valid;
    logic [15:0] cmd;
    logic [31:0] cmd_pc;
    logic        cmd_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    modport master (
        output mem_req, mem_addr, cmd_valid, cmd, cmd_pc,
        input  mem_ack, mem_rdata, cmd_ready, redirect, redirect_pc
    );

    modport slave (
        input  mem_req, mem_addr, cmd_valid, cmd, cmd_pc,
        output mem_ack, mem_rdata, cmd_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/thumb_fetch_queue.sv
// thumb_fetch_queue
//   Instruction fetch stage feeding a 16-bit Thumb executor. Fetches aligned
//   32-bit words over a single-outstanding req/ack port, splits them into
//   little-endian halfwords (low half first), buffers them in a circular
//   queue and presents one halfword plus its PC per accept. A redirect
//   flushes the queue and restarts fetch from a new PC.
//
//   Parameters:
//     DEPTH    queue depth in halfwords (power of two, >= 4)
//     RESET_PC fetch address after reset (bit 0 ignored)
//   Ports:
//     sck      clock, rising edge
//     rst_n    asynchronous active-low reset
//     bus      thumb_fetch_queue_if.master (memory port + command port)
//   Build option:
//     FETCH_BYPASS_EN  when defined, a word arriving into an empty queue is
//                      presented to the executor combinationally in the ack
//                      cycle; the accepted halfword is then not stored.
module thumb_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic             sck,
    input logic             rst_n,
    thumb_fetch_queue_if.master bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    // A request may only start when two free slots are guaranteed.
    localparam logic [CNT_W-1:0] ISSUE_MAX = CNT_W'(DEPTH - 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             mem_req_q, mem_req_d;
    logic [31:2]      mem_addr_q, mem_addr_d;
    logic [31:1]      fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [15:0]      hw_q  [DEPTH];
    logic [31:1]      pca_q [DEPTH];

    logic             q_empty;
    logic             ack_take;
    logic             ack_push;
    logic             q_pop;
    logic             byp_act;
    logic             byp_take;
    logic [1:0]       n_push;
    logic [15:0]      lo_hw, hi_hw, e0_hw;
    logic [31:1]      lo_pc, hi_pc, e0_pc;
    logic [PTR_W-1:0] wr_ptr_p1;
    logic             unused_rpc0;

    assign unused_rpc0 = bus.redirect_pc[0];

    assign q_empty   = (count_q == '0);
    // In REQ the request is always outstanding, so any ack completes it.
    assign ack_take  = (state_q == S_REQ) && bus.mem_ack;
    assign ack_push  = ack_take && !bus.redirect;

    assign lo_hw     = bus.mem_rdata[15:0];
    assign hi_hw     = bus.mem_rdata[31:16];
    assign lo_pc     = {mem_addr_q, 1'b0};
    assign hi_pc     = {mem_addr_q, 1'b1};
    assign wr_ptr_p1 = wr_ptr_q + PTR_W'(1);

`ifdef FETCH_BYPASS_EN
    logic [15:0] first_hw;
    logic [31:1] first_pc;

    // First halfword of the arriving word: the high half when the fetch
    // started at a halfword-odd PC.
    assign first_hw = fetch_pc_q[1] ? hi_hw : lo_hw;
    assign first_pc = fetch_pc_q[1] ? hi_pc : lo_pc;

    assign byp_act  = ack_push && q_empty;
    assign byp_take = byp_act && bus.cmd_ready;

    assign bus.cmd_valid = byp_act || (!q_empty && !bus.redirect);
    assign bus.cmd       = byp_act ? first_hw :
                           (q_empty ? 16'h0000 : hw_q[rd_ptr_q]);
    assign bus.cmd_pc    = byp_act ? {first_pc, 1'b0} :
                           (q_empty ? 32'h0 : {pca_q[rd_ptr_q], 1'b0});
`else
    assign byp_act  = 1'b0;
    assign byp_take = 1'b0;

    assign bus.cmd_valid = !q_empty && !bus.redirect;
    assign bus.cmd       = q_empty ? 16'h0000 : hw_q[rd_ptr_q];
    assign bus.cmd_pc    = q_empty ? 32'h0 : {pca_q[rd_ptr_q], 1'b0};
`endif

    // Queue pop is only from stored entries; redirect voids it.
    assign q_pop = !q_empty && !bus.redirect && bus.cmd_ready && !byp_act;

    assign bus.mem_req  = mem_req_q;
    assign bus.mem_addr = {mem_addr_q, 2'b00};

    // Select what the accepted word contributes to the queue. The only
    // two-entry case is {low, high}; every one-entry case stores the high half.
    always_comb begin
        n_push = 2'd0;
        e0_hw  = hi_hw;
        e0_pc  = hi_pc;
        if (ack_push) begin
            if (!fetch_pc_q[1] && !byp_take) begin
                n_push = 2'd2;
                e0_hw  = lo_hw;
                e0_pc  = lo_pc;
            end else if (!(fetch_pc_q[1] && byp_take)) begin
                n_push = 2'd1;
            end
        end
    end

    always_comb begin
        count_d  = count_q + CNT_W'(n_push) - CNT_W'(q_pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(n_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(q_pop);
        if (bus.redirect) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        fetch_pc_d = fetch_pc_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.redirect) begin
                    fetch_pc_d = bus.redirect_pc[31:1];
                end else if (count_q <= ISSUE_MAX) begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = fetch_pc_q[31:2];
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.redirect) begin
                    fetch_pc_d = bus.redirect_pc[31:1];
                    if (bus.mem_ack) begin
                        mem_req_d = 1'b0;
                        state_d   = S_IDLE;
                    end else begin
                        state_d   = S_DROP;
                    end
                end else if (bus.mem_ack) begin
                    fetch_pc_d = {mem_addr_q + 30'd1, 1'b0};
                    // Back-to-back issue uses the occupancy after this
                    // cycle's push and pop.
                    if (count_d <= ISSUE_MAX) begin
                        mem_addr_d = mem_addr_q + 30'd1;
                    end else begin
                        mem_req_d = 1'b0;
                        state_d   = S_IDLE;
                    end
                end
            end
            S_DROP: begin
                if (bus.redirect) begin
                    fetch_pc_d = bus.redirect_pc[31:1];
                end
                if (bus.mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                mem_req_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= RESET_PC[31:2];
            fetch_pc_q <= RESET_PC[31:1];
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Queue storage carries data only; occupancy is tracked by count_q.
    always_ff @(posedge sck) begin
        if (n_push != 2'd0) begin
            hw_q[wr_ptr_q]  <= e0_hw;
            pca_q[wr_ptr_q] <= e0_pc;
        end
        if (n_push == 2'd2) begin
            hw_q[wr_ptr_p1]  <= hi_hw;
            pca_q[wr_ptr_p1] <= hi_pc;
        end
    end

endmodule

// File: tb/tb_thumb_fetch_queue.sv
module tb_thumb_fetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    logic sck;
    logic rst_n;
    thumb_fetch_queue_if bus();

    thumb_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .sck   (sck),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [15:0] hw;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   pops   = 0;
    int   dmin   = 1;
    int   dmax   = 1;

    initial begin
        sck = 1'b0;
        forever #5 sck = ~sck;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Memory image: two hand-placed words, everything else {~addr, addr}.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h2001_1C08;
            32'h0000_0600: return 32'hBF00_4770;
            default:       return {~a[15:0], a[15:0]};
        endcase
    endfunction

    function automatic logic [15:0] hw_at(input logic [31:0] pc);
        logic [31:0] w;
        w = word_at({pc[31:2], 2'b00});
        return pc[1] ? w[31:16] : w[15:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %08h required %08h", name, act, req);
    endtask

    // Scoreboard load: the halfword stream expected from a start PC.
    task automatic expect_stream(input logic [31:0] start, input int n);
        exp_t e;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            e.pc = start + 32'(2 * i);
            e.hw = hw_at(e.pc);
            exp_q.push_back(e);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sck);
        #1;
    endtask

    task automatic wait_pops(input int n, input int budget, input string name);
        int base;
        int cyc;
        base = pops;
        cyc  = 0;
        while ((pops < base + n) && (cyc < budget)) begin
            @(posedge sck);
            #1;
            cyc++;
        end
        check(name, 32'(pops - base >= n), 32'd1);
    endtask

    task automatic wait_req(input logic level, input int budget, input string name);
        int cyc;
        cyc = 0;
        @(negedge sck);
        while ((bus.mem_req !== level) && (cyc < budget)) begin
            @(negedge sck);
            cyc++;
        end
        check(name, 32'(bus.mem_req), 32'(level));
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        @(posedge sck);
        #1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = pc;
        expect_stream({pc[31:1], 1'b0}, 400);
        tick(1);
        bus.redirect    = 1'b0;
    endtask

    // Memory responder: one outstanding request, delay drawn per request.
    initial begin
        bit busy;
        int wait_cnt;
        busy          = 1'b0;
        wait_cnt      = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        forever begin
            @(posedge sck);
            #1;
            bus.mem_ack = 1'b0;
            if (!rst_n) begin
                busy = 1'b0;
            end else if (bus.mem_req) begin
                if (!busy) begin
                    busy     = 1'b1;
                    wait_cnt = int'($urandom_range(dmax, dmin));
                end
                if (wait_cnt == 0) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = word_at(bus.mem_addr);
                    busy          = 1'b0;
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    // Monitor: every accepted command is checked against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge sck);
            if (rst_n && bus.cmd_valid && bus.cmd_ready) begin
                pops++;
                if (exp_q.size() == 0) begin
                    check("cmd_overrun_pc", bus.cmd_pc, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("cmd_hw", 32'(bus.cmd), 32'(e.hw));
                    check("cmd_pc", bus.cmd_pc, e.pc);
                end
            end
        end
    end

    initial begin
        rst_n           = 1'b0;
        bus.cmd_ready   = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;

        // Reset state
        @(negedge sck);
        check("rst_mem_req",   32'(bus.mem_req),   32'd0);
        check("rst_mem_addr",  bus.mem_addr,       32'h0000_0100);
        check("rst_cmd_valid", 32'(bus.cmd_valid), 32'd0);
        check("rst_cmd",       32'(bus.cmd),       32'd0);
        check("rst_cmd_pc",    bus.cmd_pc,         32'd0);

        // Basic fetch: 0x1C08 @0x100 then 0x2001 @0x102
        expect_stream(32'h100, 400);
        @(posedge sck);
        #1;
        rst_n         = 1'b1;
        bus.cmd_ready = 1'b1;
        wait_pops(2, 40, "basic_pops");
        bus.cmd_ready = 1'b0;

        // Fill: queue of 4, request dropped at 0x104, resumes at 0x108
        dmin = 0;
        dmax = 0;
        do_redirect(32'h100);
        tick(12);
        @(negedge sck);
        check("full_mem_req",   32'(bus.mem_req),   32'd0);
        check("full_mem_addr",  bus.mem_addr,       32'h0000_0104);
        check("full_cmd_valid", 32'(bus.cmd_valid), 32'd1);
        check("full_cmd",       32'(bus.cmd),       32'h1C08);
        @(posedge sck);
        #1;
        bus.cmd_ready = 1'b1;
        wait_req(1'b1, 10, "refill_req");
        check("refill_addr", bus.mem_addr, 32'h0000_0108);
        wait_pops(8, 60, "fill_pops");
        bus.cmd_ready = 1'b0;

        // Redirect to 0x203 while a request waits: drop stale word
        tick(10);
        dmin = 4;
        dmax = 4;
        do_redirect(32'h300);
        wait_req(1'b1, 10, "drop_first_req");
        @(posedge sck);
        #1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h203;
        expect_stream(32'h202, 400);
        tick(1);
        bus.redirect    = 1'b0;
        @(negedge sck);
        check("drop_hold_req",  32'(bus.mem_req), 32'd1);
        check("drop_hold_addr", bus.mem_addr,     32'h0000_0300);
        wait_req(1'b0, 10, "drop_release");
        wait_req(1'b1, 10, "drop_restart");
        check("drop_new_addr", bus.mem_addr, 32'h0000_0200);
        dmin = 0;
        dmax = 2;
        bus.cmd_ready = 1'b1;
        wait_pops(6, 80, "drop_pops");
        bus.cmd_ready = 1'b0;

        // Redirect latency and masking with a full queue
        dmin = 0;
        dmax = 0;
        tick(10);
        do_redirect(32'h400);
        tick(12);
        @(posedge sck);
        #1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h501;
        bus.cmd_ready   = 1'b1;
        expect_stream(32'h500, 400);
        @(negedge sck);
        check("redir_mask_valid", 32'(bus.cmd_valid), 32'd0);
        @(posedge sck);
        #1;
        bus.redirect = 1'b0;
        @(negedge sck);
        check("redir_n_req",       32'(bus.mem_req),   32'd0);
        check("empty_ready_valid", 32'(bus.cmd_valid), 32'd0);
        @(negedge sck);
        check("redir_n1_req",  32'(bus.mem_req), 32'd1);
        check("redir_n1_addr", bus.mem_addr,     32'h0000_0500);

        // Random ack delay and random ready
        dmin = 0;
        dmax = 5;
        begin
            int base;
            int cyc;
            base = pops;
            cyc  = 0;
            while ((pops < base + 300) && (cyc < 5000)) begin
                @(posedge sck);
                #1;
                bus.cmd_ready = 1'($urandom_range(1, 0));
                cyc++;
            end
            check("random_pops", 32'(pops - base >= 300), 32'd1);
        end
        bus.cmd_ready = 1'b0;

        // Address wrap at 2^32
        tick(10);
        dmin = 1;
        dmax = 1;
        do_redirect(32'hFFFF_FFFC);
        bus.cmd_ready = 1'b1;
        wait_pops(6, 60, "wrap_pops");
        bus.cmd_ready = 1'b0;

        // First word into an empty queue: 0xBF00_4770 at 0x600
        tick(15);
        dmin = 2;
        dmax = 2;
        @(posedge sck);
        #1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h600;
        bus.cmd_ready   = 1'b1;
        expect_stream(32'h600, 400);
        tick(1);
        bus.redirect = 1'b0;
        begin
            int cyc;
            cyc = 0;
            @(negedge sck);
            while (!bus.mem_ack && cyc < 20) begin
                @(negedge sck);
                cyc++;
            end
            check("ack_seen", 32'(bus.mem_ack), 32'd1);
`ifdef FETCH_BYPASS_EN
            check("ack_cycle_valid", 32'(bus.cmd_valid), 32'd1);
            check("ack_cycle_cmd",   32'(bus.cmd),       32'h4770);
            @(negedge sck);
            check("ack_next_valid",  32'(bus.cmd_valid), 32'd1);
            check("ack_next_cmd",    32'(bus.cmd),       32'hBF00);
`else
            check("ack_cycle_valid", 32'(bus.cmd_valid), 32'd0);
            @(negedge sck);
            check("ack_next_valid",  32'(bus.cmd_valid), 32'd1);
            check("ack_next_cmd",    32'(bus.cmd),       32'h4770);
            check("ack_next_pc",     bus.cmd_pc,         32'h0000_0600);
`endif
        end
        wait_pops(4, 40, "empty_pops");
        bus.cmd_ready = 1'b0;
        tick(4);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
